// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types, defaults and helpers for core_block_ctrl
package core_ctrl_pkg;

  localparam int TPB_DEFAULT   = 4;
  localparam int BID_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Thread counts above the core width fill every lane.
  function automatic int clamp_count(input int count, input int limit);
    return (count > limit) ? limit : count;
  endfunction

  function automatic logic lane_active(input int lane, input int count, input int limit);
    return lane < clamp_count(count, limit);
  endfunction

endpackage

// File: rtl/core_block_ctrl.sv
// rtl/core_block_ctrl.sv - per-core block launch/RET tracker; CORE_BLOCK_CYCLES_EN adds block_cycles
module core_block_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int  THREADS_PER_BLOCK = TPB_DEFAULT,
  parameter int  BLOCK_ID_WIDTH    = BID_W_DEFAULT,
  localparam int TW                = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_reset,
  input  logic                         core_start,
  input  logic [BLOCK_ID_WIDTH-1:0]    core_block_id,
  input  logic [TW-1:0]                core_thread_count,
  output logic                         core_done,
  output logic                         block_start,
  output logic [BLOCK_ID_WIDTH-1:0]    block_id,
  output logic [THREADS_PER_BLOCK-1:0] thread_mask,
  input  logic [THREADS_PER_BLOCK-1:0] thread_ret,
  output logic                         busy
`ifdef CORE_BLOCK_CYCLES_EN
  ,
  output logic [15:0]                  block_cycles
`endif
);

  state_e                         state_q, state_d;
  logic [BLOCK_ID_WIDTH-1:0]      id_q, id_d;
  logic [THREADS_PER_BLOCK-1:0]   mask_q, mask_d;
  logic [THREADS_PER_BLOCK-1:0]   ret_q, ret_d;
  logic [THREADS_PER_BLOCK-1:0]   ret_now;
  logic [THREADS_PER_BLOCK-1:0]   accept_mask;
  logic                           done_q, start_q, busy_q;

  always_comb begin
    accept_mask = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      accept_mask[i] = lane_active(i, int'(core_thread_count), THREADS_PER_BLOCK);
    end
  end

  // Completion looks at this cycle's RETs too, so done lands one edge after the last RET.
  assign ret_now = ret_q | (thread_ret & mask_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    mask_d  = mask_q;
    ret_d   = ret_q;
    case (state_q)
      ST_IDLE: begin
        if (core_start) begin
          id_d    = core_block_id;
          mask_d  = accept_mask;
          state_d = (core_thread_count != '0) ? ST_LAUNCH : ST_DONE;
        end
      end
      ST_LAUNCH: begin
        ret_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ret_d = ret_now;
        if (ret_now == mask_q) state_d = ST_DONE;
      end
      default: ;
    endcase
    if (core_reset) begin
      state_d = ST_IDLE;
      id_d    = '0;
      mask_d  = '0;
      ret_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      mask_q  <= '0;
      ret_q   <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      ret_q   <= ret_d;
      done_q  <= (state_d == ST_DONE);
      start_q <= (state_d == ST_LAUNCH);
      busy_q  <= (state_d == ST_LAUNCH) || (state_d == ST_RUN);
    end
  end

  assign core_done   = done_q;
  assign block_start = start_q;
  assign busy        = busy_q;
  assign block_id    = id_q;
  assign thread_mask = mask_q;

`ifdef CORE_BLOCK_CYCLES_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    case (state_q)
      ST_IDLE, ST_LAUNCH: cyc_d = '0;
      ST_RUN:             if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
      default: ;
    endcase
    if (core_reset) cyc_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign block_cycles = cyc_q;
`endif

endmodule
